// File: rtl/rx_frame_packer_if.sv
// Sample-memory write port of the RX frame packer.
// The packer drives it through the master modport; the memory listens on the slave modport.
interface rx_frame_packer_if #(
  parameter int AW = 11
);
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wd;

  modport master (output mem_we, output mem_addr, output mem_wd);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wd);
endinterface

// File: rtl/rx_frame_packer.sv
// RX frame packer.
// Each rx_avail strobe carries one sample set: NCHANS channels of 24-bit I/Q.
// Every sample set becomes 3*NCHANS 16-bit words in the half of a double buffer
// that is currently being filled. After nsamps sample sets, a four-word tail is
// appended: a 48-bit timestamp followed by the frame counter. The block then
// flips buffers and pulses frame_done.
module rx_frame_packer #(
  parameter int NCHANS = 4,
  parameter int AW     = 11
) (
  input  logic                  adc_clk,
  input  logic                  reset,
  input  logic                  rx_avail,
  input  logic [NCHANS*48-1:0]  iq_din,
  input  logic [7:0]            nsamps,
  input  logic [47:0]           ticks,
  input  logic                  ovr_clr,
  rx_frame_packer_if.master     mem,
  output logic                  frame_done,
  output logic                  buf_sel,
  output logic [15:0]           frame_ctr,
  output logic                  ovr
);

  localparam int CW = (NCHANS > 1) ? $clog2(NCHANS) : 1;

  typedef enum logic [1:0] {IDLE, PACK, TAIL} state_t;

  state_t               r_state;
  logic [NCHANS*48-1:0] r_shadow;
  logic [47:0]          r_ticks;
  logic [7:0]           r_nsamps;
  logic [7:0]           r_sidx;
  // One bit wider than the buffer half so that a full buffer is visible as the MSB.
  logic [AW-1:0]        r_off;
  logic [CW-1:0]        r_ch;
  logic [1:0]           r_part;
  logic [2:0]           r_tcnt;

  logic                 w_emit;
  logic [15:0]          w_word;
  logic [47:0]          w_chan;
  logic                 w_full;
  logic                 w_drop;
  logic                 w_last_word;

  // Select the shadowed {I,Q} pair of the channel currently being packed.
  always_comb begin
    w_chan = r_shadow[47:0];
    for (int k = 0; k < NCHANS; k++) begin
      if (r_ch == CW'(k)) w_chan = r_shadow[48*k +: 48];
    end
  end

  // Decide whether this cycle produces a word and which word it is.
  // The first word of a sample set comes straight from iq_din, so that it
  // appears one cycle after the strobe.
  always_comb begin
    w_emit = 1'b0;
    w_word = 16'd0;
    case (r_state)
      IDLE: begin
        if (rx_avail) begin
          w_emit = 1'b1;
          w_word = iq_din[47:32];
        end
      end
      PACK: begin
        w_emit = 1'b1;
        case (r_part)
          2'd0:    w_word = w_chan[47:32];
          2'd1:    w_word = w_chan[31:16];
          default: w_word = w_chan[15:0];
        endcase
      end
      TAIL: begin
        if (r_tcnt != 3'd4) begin
          w_emit = 1'b1;
          case (r_tcnt)
            3'd0:    w_word = r_ticks[47:32];
            3'd1:    w_word = r_ticks[31:16];
            3'd2:    w_word = r_ticks[15:0];
            default: w_word = frame_ctr;
          endcase
        end
      end
      default: begin
        w_emit = 1'b0;
        w_word = 16'd0;
      end
    endcase
    w_full      = r_off[AW-1];
    w_drop      = rx_avail && (r_state != IDLE);
    w_last_word = (r_ch == CW'(NCHANS - 1)) && (r_part == 2'd2);
  end

  // Sequencer: write port, sample/word counters, tail, and frame completion.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_ticks      <= '0;
      r_nsamps     <= '0;
      r_sidx       <= '0;
      r_off        <= '0;
      r_ch         <= '0;
      r_part       <= '0;
      r_tcnt       <= '0;
      mem.mem_we   <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wd   <= '0;
      frame_done   <= 1'b0;
      buf_sel      <= 1'b0;
      frame_ctr    <= '0;
    end else begin
      frame_done <= 1'b0;

      // Words beyond the end of the buffer half are dropped, but sequencing continues.
      if (w_emit && !w_full) begin
        mem.mem_we   <= 1'b1;
        mem.mem_addr <= {buf_sel, r_off[AW-2:0]};
        mem.mem_wd   <= w_word;
        r_off        <= r_off + AW'(1);
      end else begin
        mem.mem_we   <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (rx_avail) begin
            r_shadow <= iq_din;
            if (r_sidx == 8'd0) begin
              r_ticks  <= ticks;
              r_nsamps <= nsamps;
            end
            r_ch    <= '0;
            r_part  <= 2'd1;
            r_state <= PACK;
          end
        end
        PACK: begin
          if (w_last_word) begin
            r_ch   <= '0;
            r_part <= 2'd0;
            // nsamps of 0 wraps to 255 here, giving 256 sample sets per frame.
            if (r_sidx == r_nsamps - 8'd1) begin
              r_tcnt  <= 3'd0;
              r_state <= TAIL;
            end else begin
              r_sidx  <= r_sidx + 8'd1;
              r_state <= IDLE;
            end
          end else if (r_part == 2'd2) begin
            r_part <= 2'd0;
            r_ch   <= r_ch + CW'(1);
          end else begin
            r_part <= r_part + 2'd1;
          end
        end
        TAIL: begin
          if (r_tcnt == 3'd4) begin
            frame_done <= 1'b1;
            buf_sel    <= ~buf_sel;
            frame_ctr  <= frame_ctr + 16'd1;
            r_sidx     <= '0;
            r_off      <= '0;
            r_tcnt     <= '0;
            r_state    <= IDLE;
          end else begin
            r_tcnt <= r_tcnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky overrun flag; a new overrun in the same cycle as a clear keeps it set.
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      ovr <= 1'b0;
    end else if (w_drop || (w_emit && w_full)) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: doc/rx_frame_packer.md
RX_FRAME_PACKER -- requirements
Module: rx_frame_packer

Interface
REQ-001 The block SHALL have parameter NCHANS, default 4, giving the number of DDC channels packed per sample set.
REQ-002 The block SHALL have parameter AW, default 11, giving the memory word-address width; mem_addr[AW-1] is the buffer select.
REQ-003 The block SHALL have port adc_clk, input, 1, the sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port rx_avail, input, 1, a one-cycle strobe marking iq_din valid.
REQ-006 The block SHALL have port iq_din, input, NCHANS*48, where channel k is {I[23:0],Q[23:0]} at bits [48k+47:48k].
REQ-007 The block SHALL have port nsamps, input, 8, giving sample sets per frame, where 0 means 256.
REQ-008 The block SHALL have port ticks, input, 48, the free-running timestamp.
REQ-009 The block SHALL have port ovr_clr, input, 1, which clears ovr.
REQ-010 The block SHALL have ports mem_we (output, 1), mem_addr (output, AW) and mem_wd (output, 16), forming the sample-memory write port.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse when a frame completes.
REQ-012 The block SHALL have port buf_sel, output, 1, the buffer currently being filled.
REQ-013 The block SHALL have port frame_ctr, output, 16, counting completed frames.
REQ-014 The block SHALL have port ovr, output, 1, a sticky flag for a dropped sample or buffer overflow.

Function
REQ-015 The FSM SHALL have states IDLE, PACK and TAIL, and SHALL write at most one word per cycle.
REQ-016 On rx_avail in IDLE, the block SHALL latch iq_din into a shadow register and enter PACK; the first mem_we SHALL occur in the next cycle (latency 1).
REQ-017 If the sample index is 0 at that rx_avail, the block SHALL also latch ticks and nsamps; later changes to nsamps within the frame SHALL be ignored.
REQ-018 In PACK, for channel k = 0..NCHANS-1, the block SHALL write three words in order: I[23:8], {I[7:0],Q[23:16]}, Q[15:0], giving 3*NCHANS consecutive cycles with mem_we=1.
REQ-019 After the last PACK word, if the sample index equals nsamps_latched-1, the block SHALL enter TAIL; otherwise it SHALL increment the sample index and return to IDLE.
REQ-020 TAIL SHALL write four words: ticks[47:32], ticks[31:16], ticks[15:0], frame_ctr (value before increment).
REQ-021 In the cycle after the last TAIL word, the block SHALL assert frame_done, toggle buf_sel, increment frame_ctr (wrapping 0xFFFF->0), clear the sample index and word offset, and return to IDLE.
REQ-022 mem_addr SHALL equal {buf_sel, offset[AW-2:0]}, where offset starts at 0 per frame and increments after each write.
REQ-023 If offset would exceed 2^(AW-1)-1, further writes in that frame SHALL be suppressed (mem_we=0), ovr SHALL be set, and sequencing and frame_done SHALL proceed normally.
REQ-024 rx_avail arriving in PACK or TAIL SHALL be dropped, set ovr, and leave FSM, shadow and counters unaffected.
REQ-025 ovr_clr SHALL clear ovr the next cycle; if ovr_clr and a set condition coincide, set SHALL win.
REQ-026 mem_we SHALL be 0 in IDLE, and mem_wd/mem_addr SHALL be don't-care whenever mem_we=0.

Reset
REQ-027 Asserting reset SHALL immediately force: state IDLE; mem_we=0; mem_addr=0; mem_wd=0; frame_done=0; buf_sel=0; frame_ctr=0; ovr=0; sample index=0; offset=0; and shadow, ticks and nsamps latches=0.
REQ-028 Reset during PACK/TAIL SHALL abandon the partial frame without a frame_done pulse.
REQ-029 After reset deasserts, the first rx_avail SHALL be treated as sample 0 of a new frame.

Verification
REQ-030 The bench SHALL cover: NCHANS=4, nsamps=2, ticks=0x0000_1234_5678, ch0 I=0xABCDEF, Q=0x123456, and two rx_avail 20 cycles apart -> 12 writes at buf 0 addr 0..11 with word0=0xABCD, word1=0xEF12, word2=0x3456; then 12 at 12..23; then TAIL 0x0000,0x1234,0x5678,0x0000 at 24..27; then frame_done, buf_sel=1, frame_ctr=1.
REQ-031 The bench SHALL cover: a second frame after REQ-030 -> addresses 0x400..0x41B and TAIL last word 0x0001.
REQ-032 The bench SHALL cover: rx_avail 5 cycles after a prior rx_avail -> ovr=1, exactly 12 writes for that sample, and sample index unchanged by the dropped strobe.
REQ-033 The bench SHALL cover: AW=6, NCHANS=4, nsamps=3 -> writes stop at offset 31, ovr=1, and frame_done still asserts after 40 sequencing cycles.
REQ-034 The bench SHALL cover: reset asserted mid-PACK, then a new frame with nsamps=1 -> writes restart at addr 0, no stale frame_done, and frame_ctr word 0x0000.
REQ-035 The bench SHALL cover: ovr_clr coincident with a dropped rx_avail -> ovr remains 1; ovr_clr alone the next cycle -> ovr=0.
